// File: rtl/sparce_sasa_table.sv
// Skip-Address-Slot-Array table: software-programmed skip entries looked up by fetch PC.
// Latency: lookup result registered 1 cycle after the PC edge; table writes visible the cycle after commit.
// Backpressure: none; stores are never refused, lookup stage simply holds while if_ex_enable is low.
//
// Ports:
//   CLK, nRST                      clock, synchronous active-low reset
//   pc, if_ex_enable               fetch PC and lookup-stage advance
//   sasa_addr/sasa_data/sasa_wen   configuration store port (entry write / clear-all)
//   sasa_hit, sasa_pc, sasa_rs1, sasa_rs2, sasa_cond, sasa_insts   registered lookup result
//   sasa_busy                      first word of a two-word entry write has been taken
module sparce_sasa_table #(
    parameter int unsigned SASA_ENTRIES  = 16,
    parameter logic [31:0] SASA_ADDR     = 32'h0000_1024,
    parameter logic [31:0] SASA_CLR_ADDR = 32'h0000_1028
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic        if_ex_enable,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    input  logic        sasa_wen,
    output logic        sasa_hit,
    output logic [31:0] sasa_pc,
    output logic [4:0]  sasa_rs1,
    output logic [4:0]  sasa_rs2,
    output logic [1:0]  sasa_cond,
    output logic [15:0] sasa_insts,
    output logic        sasa_busy
);
    localparam int unsigned IDX_W = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;

    typedef enum logic {IDLE, GOT_PC} state_e;

    typedef struct packed {
        logic [29:0] tag;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  cond;
        logic [15:0] insts;
    } entry_t;

    // Table storage; only the valid bits need a reset value.
    entry_t                  table_q [SASA_ENTRIES];
    logic [SASA_ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    state_e                  state_q, state_d;
    logic [29:0]             pc_lat_q, pc_lat_d;

    // Registered lookup stage
    logic        hit_q;
    logic [31:0] pc_q;
    logic [4:0]  rs1_q, rs2_q;
    logic [1:0]  cond_q;
    logic [15:0] insts_q;

    // Store decode
    logic st_wen, clr_wen;
    assign st_wen  = sasa_wen && (sasa_addr == SASA_ADDR);
    assign clr_wen = sasa_wen && (sasa_addr == SASA_CLR_ADDR);

    // Word 1 of an entry write combined with the latched trigger PC
    entry_t new_entry;
    assign new_entry = '{tag:   pc_lat_q,
                         rs1:   sasa_data[31:27],
                         rs2:   sasa_data[26:22],
                         cond:  sasa_data[21:20],
                         insts: sasa_data[15:0]};

    // Bits of the inputs that carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], sasa_data[19:16]};

    // Commit-side tag match: does the latched PC already own a slot?
    logic             cm_hit;
    logic [IDX_W-1:0] cm_idx;
    always_comb begin
        cm_hit = 1'b0;
        cm_idx = '0;
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            if (valid_q[i] && (table_q[i].tag == pc_lat_q)) begin
                cm_hit = 1'b1;
                cm_idx = IDX_W'(i);
            end
        end
    end

    // Lookup-side match against the pre-write table contents; tags are unique
    // so at most one slot can contribute.
    logic        lk_hit;
    logic [4:0]  lk_rs1, lk_rs2;
    logic [1:0]  lk_cond;
    logic [15:0] lk_insts;
    always_comb begin
        lk_hit   = 1'b0;
        lk_rs1   = '0;
        lk_rs2   = '0;
        lk_cond  = '0;
        lk_insts = '0;
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            if (valid_q[i] && (table_q[i].tag == pc[31:2])) begin
                lk_hit   = 1'b1;
                lk_rs1   = table_q[i].rs1;
                lk_rs2   = table_q[i].rs2;
                lk_cond  = table_q[i].cond;
                lk_insts = table_q[i].insts;
            end
        end
    end

    // Write FSM next state and commit placement
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_idx;
    always_comb begin
        state_d  = state_q;
        pc_lat_d = pc_lat_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        tbl_we   = 1'b0;
        tbl_idx  = rr_ptr_q;
        if (clr_wen) begin
            // Clear also aborts a half-written entry
            valid_d  = '0;
            rr_ptr_d = '0;
            state_d  = IDLE;
        end else if (st_wen) begin
            if (state_q == IDLE) begin
                pc_lat_d = sasa_data[31:2];
                state_d  = GOT_PC;
            end else begin
                state_d = IDLE;
                if (new_entry.insts == 16'd0) begin
                    // Zero-length skip means "remove"; absent tag is a no-op
                    if (cm_hit) begin
                        valid_d[cm_idx] = 1'b0;
                    end
                end else if (cm_hit) begin
                    // Update in place so a tag never occupies two slots
                    tbl_we  = 1'b1;
                    tbl_idx = cm_idx;
                end else begin
                    tbl_we            = 1'b1;
                    tbl_idx           = rr_ptr_q;
                    valid_d[rr_ptr_q] = 1'b1;
                    rr_ptr_d          = (rr_ptr_q == IDX_W'(SASA_ENTRIES - 1)) ? '0 : rr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            pc_lat_q <= '0;
            valid_q  <= '0;
            rr_ptr_q <= '0;
            hit_q    <= 1'b0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            cond_q   <= '0;
            insts_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_lat_q <= pc_lat_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            if (tbl_we) begin
                table_q[tbl_idx] <= new_entry;
            end
            if (if_ex_enable) begin
                hit_q   <= lk_hit;
                pc_q    <= pc;
                rs1_q   <= lk_rs1;
                rs2_q   <= lk_rs2;
                cond_q  <= lk_cond;
                insts_q <= lk_insts;
            end
        end
    end

    assign sasa_hit   = hit_q;
    assign sasa_pc    = pc_q;
    assign sasa_rs1   = rs1_q;
    assign sasa_rs2   = rs2_q;
    assign sasa_cond  = cond_q;
    assign sasa_insts = insts_q;
    assign sasa_busy  = (state_q == GOT_PC);

endmodule

// File: tb/tb_sparce_sasa_table.sv
// Self-checking bench for sparce_sasa_table.
// Expected lookup results are queued when a lookup cycle is driven and compared after its edge.
// Stimulus is fixed-length; nothing waits on the DUT.
module tb_sparce_sasa_table;
    localparam logic [31:0] SA = 32'h0000_1024;
    localparam logic [31:0] CA = 32'h0000_1028;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc;
    logic        if_ex_enable;
    logic [31:0] sasa_addr;
    logic [31:0] sasa_data;
    logic        sasa_wen;
    logic        sasa_hit;
    logic [31:0] sasa_pc;
    logic [4:0]  sasa_rs1;
    logic [4:0]  sasa_rs2;
    logic [1:0]  sasa_cond;
    logic [15:0] sasa_insts;
    logic        sasa_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [60:0] v;
        string       name;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    sparce_sasa_table dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc           (pc),
        .if_ex_enable (if_ex_enable),
        .sasa_addr    (sasa_addr),
        .sasa_data    (sasa_data),
        .sasa_wen     (sasa_wen),
        .sasa_hit     (sasa_hit),
        .sasa_pc      (sasa_pc),
        .sasa_rs1     (sasa_rs1),
        .sasa_rs2     (sasa_rs2),
        .sasa_cond    (sasa_cond),
        .sasa_insts   (sasa_insts),
        .sasa_busy    (sasa_busy)
    );

    function automatic logic [60:0] pack(input logic h, input logic [31:0] p, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [1:0] c, input logic [15:0] n);
        return {h, p, r1, r2, c, n};
    endfunction

    function automatic logic [60:0] obs();
        return {sasa_hit, sasa_pc, sasa_rs1, sasa_rs2, sasa_cond, sasa_insts};
    endfunction

    // Word 1 layout; ign lands in the don't-care bits [19:16]
    function automatic logic [31:0] w1(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] c,
                                       input logic [15:0] n, input logic [3:0] ign);
        return {r1, r2, c, ign, n};
    endfunction

    // One clock: apply inputs, take the edge, land 1 time unit after it
    task automatic cyc(input logic en, input logic [31:0] p, input logic wen,
                       input logic [31:0] a, input logic [31:0] d);
        if_ex_enable = en;
        pc           = p;
        sasa_wen     = wen;
        sasa_addr    = a;
        sasa_data    = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, pc, 1'b1, a, d);
    endtask

    task automatic write_entry(input logic [31:0] p, input logic [31:0] word1);
        store(SA, p);
        store(SA, word1);
    endtask

    task automatic expect_out(input logic [60:0] v, input string name);
        exp_t e;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic lookup(input logic [31:0] p, input logic [60:0] v, input string name);
        expect_out(v, name);
        cyc(1'b1, p, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        exp_t e;
        nRST = 1'b0;
        expect_out(pack(0, 32'h0, 0, 0, 0, 0), "reset_outputs");
        cyc(1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        checks++;
        if (sasa_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", sasa_busy);
        end
        nRST = 1'b1;
        lookup(32'h200, pack(0, 32'h200, 0, 0, 0, 0), "empty_lookup_200");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_write_lookup();
        exp_t e;
        store(SA, 32'h200);
        checks++;
        if (sasa_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_word0: got %b expected 1", sasa_busy);
        end
        store(SA, w1(5, 6, 2'b00, 16'd3, 4'hA));
        checks++;
        if (sasa_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_word1: got %b expected 0", sasa_busy);
        end
        lookup(32'h200, pack(1, 32'h200, 5, 6, 0, 3), "hit_200");
        lookup(32'h202, pack(1, 32'h202, 5, 6, 0, 3), "hit_202_low_bits");
        lookup(32'h204, pack(0, 32'h204, 0, 0, 0, 0), "miss_204");
        while (sb.size() > 0) begin
            // Results come out one per lookup cycle; all three cycles have already run,
            // so only the last is still on the outputs.
            e = sb.pop_front();
            if (sb.size() == 0) begin
                checks++;
                if (obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
                end
            end
        end
        // Re-check the hit cases one at a time
        for (int k = 0; k < 2; k++) begin
            logic [31:0] p;
            p = (k == 0) ? 32'h200 : 32'h202;
            lookup(p, pack(1, p, 5, 6, 0, 3), $sformatf("hit_%0h", p));
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_fill_wrap();
        exp_t e;
        logic [31:0] p;
        store(CA, 32'h0);
        for (int i = 0; i < 16; i++) begin
            write_entry(32'h100 + 32'(4 * i) + 32'(i % 4),
                        w1(5'(i), 5'(i + 1), 2'(i % 4), 16'(i + 1), 4'h0));
        end
        // 17th distinct tag evicts slot 0 (0x100)
        write_entry(32'h400, w1(31, 30, 2'b11, 16'hBEEF, 4'h5));
        lookup(32'h100, pack(0, 32'h100, 0, 0, 0, 0), "evicted_100");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        lookup(32'h400, pack(1, 32'h400, 31, 30, 3, 16'hBEEF), "hit_400");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        for (int i = 1; i < 16; i++) begin
            p = 32'h100 + 32'(4 * i);
            lookup(p, pack(1, p, 5'(i), 5'(i + 1), 2'(i % 4), 16'(i + 1)), $sformatf("fill_hit_%0d", i));
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
            end
        end
        // In-place update must not advance the pointer (still at slot 1)
        write_entry(32'h104, w1(7, 8, 2'b10, 16'd9, 4'h0));
        write_entry(32'h500, w1(1, 1, 2'b01, 16'd1, 4'h0));
        // Remove 0x10C and try to remove an absent tag; pointer stays at slot 2
        write_entry(32'h10C, w1(3, 3, 2'b00, 16'd0, 4'h0));
        write_entry(32'h7000, w1(3, 3, 2'b00, 16'd0, 4'h0));
        write_entry(32'h504, w1(2, 2, 2'b10, 16'd2, 4'h0));
        expect_out(pack(0, 32'h104, 0, 0, 0, 0), "rr_evicts_104");
        expect_out(pack(0, 32'h108, 0, 0, 0, 0), "rr_evicts_108");
        expect_out(pack(0, 32'h10C, 0, 0, 0, 0), "invalidated_10c");
        expect_out(pack(1, 32'h110, 4, 5, 0, 5), "hit_110");
        expect_out(pack(1, 32'h500, 1, 1, 1, 1), "hit_500");
        expect_out(pack(1, 32'h504, 2, 2, 2, 2), "hit_504");
        expect_out(pack(1, 32'h400, 31, 30, 3, 16'hBEEF), "hit_400_again");
        foreach (sb[k]) begin
            cyc(1'b1, sb[k].v[59:28], 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs() !== sb[k].v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", sb[k].name, obs(), sb[k].v);
            end
        end
        sb.delete();
    endtask

    task automatic test_update_in_place();
        exp_t e;
        // Table after fill test: 0x400@0, 0x500@1, 0x504@2, rr=3. Update 0x110 in place.
        write_entry(32'h110, w1(7, 8, 2'b10, 16'd9, 4'h0));
        lookup(32'h110, pack(1, 32'h110, 7, 8, 2, 9), "update_110");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        // Next new tag goes to slot 3 (0x10C slot, already invalid), so 0x114 survives
        write_entry(32'h800, w1(4, 4, 2'b01, 16'd4, 4'h0));
        lookup(32'h114, pack(1, 32'h114, 5, 6, 1, 6), "survivor_114");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_clear_abort();
        exp_t e;
        store(SA, 32'h300);
        store(CA, 32'hDEAD_BEEF);
        checks++;
        if (sasa_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_aborts_busy: got %b expected 0", sasa_busy);
        end
        store(SA, 32'h500);
        store(32'h0000_2000, 32'h1234_5678);
        checks++;
        if (sasa_busy !== 1'b1) begin
            errors++;
            $display("FAIL other_addr_keeps_busy: got %b expected 1", sasa_busy);
        end
        lookup(32'h500, pack(0, 32'h500, 0, 0, 0, 0), "no_entry_yet_500");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        store(SA, w1(1, 2, 2'b01, 16'd4, 4'h0));
        expect_out(pack(1, 32'h500, 1, 2, 1, 4), "new_500_after_clear");
        expect_out(pack(0, 32'h300, 0, 0, 0, 0), "aborted_300");
        expect_out(pack(0, 32'h400, 0, 0, 0, 0), "cleared_400");
        foreach (sb[k]) begin
            cyc(1'b1, sb[k].v[59:28], 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs() !== sb[k].v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", sb[k].name, obs(), sb[k].v);
            end
        end
        sb.delete();
    endtask

    task automatic test_same_edge();
        exp_t e;
        store(SA, 32'h600);
        expect_out(pack(0, 32'h600, 0, 0, 0, 0), "same_edge_commit_miss");
        cyc(1'b1, 32'h600, 1'b1, SA, w1(3, 4, 2'b11, 16'd7, 4'h0));
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        lookup(32'h600, pack(1, 32'h600, 3, 4, 3, 7), "next_edge_hit_600");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        expect_out(pack(1, 32'h600, 3, 4, 3, 7), "same_edge_clear_hit");
        cyc(1'b1, 32'h600, 1'b1, CA, 32'h0);
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        lookup(32'h600, pack(0, 32'h600, 0, 0, 0, 0), "after_clear_miss_600");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        lookup(32'h700, pack(0, 32'h700, 0, 0, 0, 0), "miss_700");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        for (int k = 0; k < 3; k++) begin
            expect_out(pack(0, 32'h700, 0, 0, 0, 0), $sformatf("hold_%0d", k));
            case (k)
                0:       cyc(1'b0, 32'h704, 1'b1, SA, 32'h704);
                1:       cyc(1'b0, 32'h708, 1'b1, SA, w1(9, 10, 2'b10, 16'd11, 4'h0));
                default: cyc(1'b0, 32'h704, 1'b0, 32'h0, 32'h0);
            endcase
            e = sb.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
            end
        end
        lookup(32'h704, pack(1, 32'h704, 9, 10, 2, 11), "enable_resumes_704");
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // Reset in the middle of a two-word write discards the latched PC
        store(SA, 32'h900);
        nRST = 1'b0;
        expect_out(pack(0, 32'h0, 0, 0, 0, 0), "midseq_reset_outputs");
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        nRST = 1'b1;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, obs(), e.v);
        end
        checks++;
        if (sasa_busy !== 1'b0) begin
            errors++;
            $display("FAIL midseq_reset_busy: got %b expected 0", sasa_busy);
        end
        // sasa_wen held high three cycles = three stores
        store(SA, 32'hA00);
        store(SA, w1(12, 13, 2'b01, 16'd14, 4'h0));
        store(SA, 32'hB00);
        checks++;
        if (sasa_busy !== 1'b1) begin
            errors++;
            $display("FAIL third_store_busy: got %b expected 1", sasa_busy);
        end
        expect_out(pack(1, 32'hA00, 12, 13, 1, 14), "b2b_hit_a00");
        expect_out(pack(0, 32'h900, 0, 0, 0, 0), "discarded_900");
        expect_out(pack(0, 32'h704, 0, 0, 0, 0), "reset_cleared_704");
        expect_out(pack(1, 32'hA00, 12, 13, 1, 14), "b2b_hit_a00_again");
        foreach (sb[k]) begin
            cyc(1'b1, sb[k].v[59:28], 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs() !== sb[k].v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", sb[k].name, obs(), sb[k].v);
            end
        end
        sb.delete();
    endtask

    initial begin
        nRST         = 1'b0;
        pc           = 32'h0;
        if_ex_enable = 1'b0;
        sasa_addr    = 32'h0;
        sasa_data    = 32'h0;
        sasa_wen     = 1'b0;
        test_reset();
        test_write_lookup();
        test_fill_wrap();
        test_update_in_place();
        test_clear_abort();
        test_same_edge();
        test_enable_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
